// File: rtl/print_stat_timestamp_fifo.sv
// Timestamped print-stat event FIFO: captures {ctr, tag} on every snooped event,
// presents entries in order to a yumi-style consumer, and counts events lost to overflow.
module print_stat_timestamp_fifo #(
  parameter int data_width_p = 32,
  parameter int ctr_width_p  = 64,
  parameter int els_p        = 8,
  parameter int drop_width_p = 16
) (
  input  logic                                clk_i,
  input  logic                                reset_ni,
  input  logic                                v_i,
  input  logic [data_width_p-1:0]             tag_i,
  input  logic [ctr_width_p-1:0]              ctr_i,
  output logic                                v_o,
  output logic [ctr_width_p+data_width_p-1:0] data_o,
  input  logic                                yumi_i,
  output logic [$clog2(els_p+1)-1:0]          count_o,
  output logic                                full_o,
  output logic [drop_width_p-1:0]             drop_count_o,
  input  logic                                clear_drops_i
);

  localparam int ptr_w   = $clog2(els_p);
  localparam int cnt_w   = $clog2(els_p+1);
  localparam int entry_w = ctr_width_p + data_width_p;

  logic [entry_w-1:0]      mem [els_p];
  logic [ptr_w-1:0]        head_reg;
  logic [ptr_w-1:0]        tail_reg;
  logic [cnt_w-1:0]        count_reg;
  logic [cnt_w-1:0]        count_next;
  logic [drop_width_p-1:0] drop_reg;
  logic [drop_width_p-1:0] drop_next;
  logic                    deq;
  logic                    enq;
  logic                    drop;

  assign v_o          = (count_reg != '0);
  assign full_o       = (count_reg == cnt_w'(els_p));
  assign count_o      = count_reg;
  assign drop_count_o = drop_reg;
  assign data_o       = mem[head_reg];

  // A dequeue in the same cycle frees the slot, so a full FIFO still accepts the event.
  assign deq  = yumi_i & v_o;
  assign enq  = v_i & (~full_o | deq);
  assign drop = v_i & full_o & ~deq;

  always_comb begin
    count_next = count_reg;
    case ({enq, deq})
      2'b10:   count_next = count_reg + cnt_w'(1);
      2'b01:   count_next = count_reg - cnt_w'(1);
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    drop_next = drop_reg;
    if (clear_drops_i)
      drop_next = '0;
    else if (drop && (drop_reg != '1))
      drop_next = drop_reg + drop_width_p'(1);
  end

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk_i) begin
    if (enq)
      mem[tail_reg] <= {ctr_i, tag_i};
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      drop_reg  <= '0;
    end else begin
      if (deq)
        head_reg <= head_reg + ptr_w'(1);
      if (enq)
        tail_reg <= tail_reg + ptr_w'(1);
      count_reg <= count_next;
      drop_reg  <= drop_next;
    end
  end

  yumi_without_valid: assert property (@(posedge clk_i) disable iff (!reset_ni) !(yumi_i && !v_o));

endmodule
